// File: rtl/drenador_salidas.sv
// drenador_salidas: consumer end of the VC datapath. Drains output FIFOs F4..F7 with a
// round-robin, burst-limited arbiter, forwards each word with its source index and keeps a
// word counter per destination that can be read back through the req/idx handshake.
// Build option: define COUNTER_SATURATE_EN to make the word counters stick at their maximum
// value instead of wrapping to zero.
module drenador_salidas #(
    parameter int unsigned TAMANO_DATOS = 12,
    parameter int unsigned CNT_W        = 5
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic [2:0]              burst_max,
    input  logic [3:0]              empty,
    input  logic [TAMANO_DATOS-1:0] data_out4,
    input  logic [TAMANO_DATOS-1:0] data_out5,
    input  logic [TAMANO_DATOS-1:0] data_out6,
    input  logic [TAMANO_DATOS-1:0] data_out7,
    output logic [3:0]              pop,
    output logic                    data_valid,
    output logic [TAMANO_DATOS-1:0] data_rx,
    output logic [1:0]              dest_rx,
    input  logic                    req,
    input  logic [2:0]              idx,
    output logic                    cnt_valid,
    output logic [CNT_W-1:0]        cnt_data,
    output logic                    idle
);

    typedef enum logic [1:0] {StReset, StInit, StIdle, StActive} state_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e                  state_q, state_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [2:0]              bcnt_q, bcnt_d;
    logic [2:0]              bmax_q;
    logic [1:0]              grant;
    logic [1:0]              cand;
    logic                    found;
    logic                    s1_valid_q;
    logic [1:0]              s1_dest_q;
    logic [TAMANO_DATOS-1:0] data_sel;
    logic [CNT_W-1:0]        cnt_q [4];
    logic                    rd_ok;

    // Next state; init wins from any state
    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = StInit;
        end else begin
            case (state_q)
                StReset:  state_d = StInit;
                StInit:   state_d = StIdle;
                StIdle:   if (!(&empty)) state_d = StActive;
                StActive: if (&empty) state_d = StIdle;
                default:  state_d = StReset;
            endcase
        end
    end

    // Arbiter: keep the current FIFO until it empties or its burst is used up, then search
    // ptr+1, ptr+2, ptr+3 and finally ptr itself so a lone non-empty FIFO is still served
    always_comb begin
        pop    = 4'b0000;
        grant  = ptr_q;
        ptr_d  = ptr_q;
        bcnt_d = bcnt_q;
        cand   = ptr_q;
        found  = 1'b0;
        if (state_q == StActive) begin
            if (!empty[ptr_q] && (bcnt_q < bmax_q)) begin
                found  = 1'b1;
                bcnt_d = bcnt_q + 3'd1;
            end else begin
                for (int i = 1; i <= 4; i++) begin
                    cand = ptr_q + 2'(i);
                    if (!found && !empty[cand]) begin
                        found  = 1'b1;
                        grant  = cand;
                        ptr_d  = cand;
                        bcnt_d = 3'd1;
                    end
                end
            end
            if (found) pop[grant] = 1'b1;
        end
    end

    // Source select for the word the FIFOs present one cycle after the pop
    always_comb begin
        data_sel = data_out4;
        case (s1_dest_q)
            2'd0:    data_sel = data_out4;
            2'd1:    data_sel = data_out5;
            2'd2:    data_sel = data_out6;
            default: data_sel = data_out7;
        endcase
        idle  = (state_q == StIdle);
        rd_ok = req && ((state_q == StIdle) || (state_q == StActive));
    end

    // FSM, arbiter pointer, burst count and latched burst limit
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= StReset;
            ptr_q   <= 2'd0;
            bcnt_q  <= 3'd0;
            bmax_q  <= 3'd1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            if (state_q == StInit) bmax_q <= (burst_max == 3'd0) ? 3'd1 : burst_max;
        end
    end

    // Two-stage read pipe: pop -> FIFO data -> registered output word
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            s1_valid_q <= 1'b0;
            s1_dest_q  <= 2'd0;
            data_valid <= 1'b0;
            data_rx    <= '0;
            dest_rx    <= 2'd0;
        end else begin
            s1_valid_q <= |pop;
            s1_dest_q  <= grant;
            data_valid <= s1_valid_q;
            if (s1_valid_q) begin
                data_rx <= data_sel;
                dest_rx <= s1_dest_q;
            end
        end
    end

    // Per-destination counters; a read in the same cycle sees the pre-increment value
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
            cnt_valid <= 1'b0;
            cnt_data  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (s1_valid_q && (s1_dest_q == 2'(k))) begin
`ifdef COUNTER_SATURATE_EN
                    if (cnt_q[k] != CntMax) cnt_q[k] <= cnt_q[k] + CntOne;
`else
                    cnt_q[k] <= cnt_q[k] + CntOne;
`endif
                end
            end
            cnt_valid <= rd_ok;
            cnt_data  <= (rd_ok && idx[2]) ? cnt_q[idx[1:0]] : '0;
        end
    end

endmodule

// File: tb/tb_drenador_salidas.sv
// Bench for drenador_salidas: a behavioural FIFO model feeds F4..F7, the stimulus pushes
// expected pops, words and counter values into queues, and a monitor compares them whenever
// the DUT presents a pop, a data_valid or a cnt_valid.
module tb_drenador_salidas;

    localparam int unsigned TD = 12;
    localparam int unsigned CW = 5;
`ifdef COUNTER_SATURATE_EN
    localparam logic [CW-1:0] F4Count = 5'd31;
`else
    localparam logic [CW-1:0] F4Count = 5'd1;
`endif

    logic          clk = 1'b0;
    logic          reset_L;
    logic          init;
    logic [2:0]    burst_max;
    logic [3:0]    empty;
    logic [TD-1:0] dout [4];
    logic [3:0]    pop;
    logic          data_valid;
    logic [TD-1:0] data_rx;
    logic [1:0]    dest_rx;
    logic          req;
    logic [2:0]    idx;
    logic          cnt_valid;
    logic [CW-1:0] cnt_data;
    logic          idle;

    drenador_salidas #(.TAMANO_DATOS(TD), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .init       (init),
        .burst_max  (burst_max),
        .empty      (empty),
        .data_out4  (dout[0]),
        .data_out5  (dout[1]),
        .data_out6  (dout[2]),
        .data_out7  (dout[3]),
        .pop        (pop),
        .data_valid (data_valid),
        .data_rx    (data_rx),
        .dest_rx    (dest_rx),
        .req        (req),
        .idx        (idx),
        .cnt_valid  (cnt_valid),
        .cnt_data   (cnt_data),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [TD-1:0]   fq [4][$];
    logic [3:0]      exp_pop [$];
    logic [TD+1:0]   exp_data [$];
    int              exp_lat [$];
    logic [CW-1:0]   exp_cnt [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0h, expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // FIFO model: a pop seen in cycle N presents the head word from the next edge on
    initial begin : fifo_model
        logic [3:0] p;
        empty = 4'hF;
        for (int k = 0; k < 4; k++) dout[k] = '0;
        forever begin
            @(negedge clk);
            p = pop;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (p[k] && reset_L && fq[k].size() != 0) dout[k] = fq[k].pop_front();
                empty[k] = (fq[k].size() == 0);
            end
        end
    end

    // Monitor: compares every DUT output event against the scoreboard queues
    initial begin : monitor
        logic [3:0]    ep;
        logic [TD+1:0] ed;
        int            el;
        logic [CW-1:0] ec;
        forever begin
            @(negedge clk);
            if (reset_L) begin
                if (pop != 4'b0000) begin
                    check("pop_onehot", 32'($onehot(pop)), 32'd1);
                    check("pop_nonempty", 32'(pop & empty), 32'd0);
                    if (exp_pop.size() != 0) begin
                        ep = exp_pop.pop_front();
                        check("pop_order", 32'(pop), 32'(ep));
                    end else begin
                        unexpected("pop_order", 32'(pop));
                    end
                    exp_lat.push_back(cyc + 2);
                end
                if (data_valid) begin
                    if (exp_data.size() != 0) begin
                        ed = exp_data.pop_front();
                        check("data_rx", 32'(data_rx), 32'(ed[TD-1:0]));
                        check("dest_rx", 32'(dest_rx), 32'(ed[TD+1:TD]));
                    end else begin
                        unexpected("data_rx", 32'(data_rx));
                    end
                    if (exp_lat.size() != 0) begin
                        el = exp_lat.pop_front();
                        check("latency", 32'(cyc), 32'(el));
                    end else begin
                        unexpected("latency", 32'(cyc));
                    end
                end
                if (cnt_valid) begin
                    if (exp_cnt.size() != 0) begin
                        ec = exp_cnt.pop_front();
                        check("cnt_data", 32'(cnt_data), 32'(ec));
                    end else begin
                        unexpected("cnt_valid", 32'(cnt_data));
                    end
                end
            end
        end
    end

    task automatic load(input int k, input logic [TD-1:0] w);
        fq[k].push_back(w);
    endtask

    task automatic expect_word(input int k, input logic [TD-1:0] w);
        exp_pop.push_back(4'(1 << k));
        exp_data.push_back({2'(k), w});
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((exp_data.size() != 0 || exp_pop.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(exp_data.size() + exp_pop.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic read_cnt(input logic [2:0] i, input logic [CW-1:0] e);
        req = 1'b1;
        idx = i;
        exp_cnt.push_back(e);
        @(negedge clk);
    endtask

    task automatic end_reads();
        req = 1'b0;
        repeat (2) @(negedge clk);
        check("cnt_left", 32'(exp_cnt.size()), 32'd0);
        check("cnt_valid_off", 32'(cnt_valid), 32'd0);
    endtask

    function automatic logic [TD-1:0] w2(input int k, input int j);
        return {4'(k), 8'(8'hA0 + j)};
    endfunction

    initial begin : stim
        int n;
        reset_L   = 1'b0;
        init      = 1'b0;
        burst_max = 3'd0;
        req       = 1'b0;
        idx       = 3'd0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_pop", 32'(pop), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_data_rx", 32'(data_rx), 32'd0);
        check("rst_dest_rx", 32'(dest_rx), 32'd0);
        check("rst_cnt_valid", 32'(cnt_valid), 32'd0);
        check("rst_cnt_data", 32'(cnt_data), 32'd0);
        check("rst_idle", 32'(idle), 32'd0);

        // Burst of 2 across all four FIFOs; req in INIT is ignored
        init      = 1'b1;
        burst_max = 3'd2;
        #2 reset_L = 1'b1;
        @(negedge clk);
        check("idle_init", 32'(idle), 32'd0);
        req = 1'b1;
        idx = 3'b110;
        @(negedge clk);
        check("cnt_valid_init", 32'(cnt_valid), 32'd0);
        req = 1'b0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) load(k, w2(k, j));
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                for (int j = 2 * r; j < 2 * r + 2; j++) expect_word(k, w2(k, j));
        @(negedge clk);
        check("pop_in_init", 32'(pop), 32'd0);
        init = 1'b0;
        drain(60);
        check("idle_after_burst2", 32'(idle), 32'd1);

        // Only F6 with three words, burst 1: three back-to-back pops
        init      = 1'b1;
        burst_max = 3'd1;
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            load(2, 12'h3C0 + 12'(j));
            expect_word(2, 12'h3C0 + 12'(j));
        end
        n = 0;
        while (pop == 4'b0000 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("f6_pop0", 32'(pop), 32'h4);
        @(negedge clk);
        check("f6_pop1", 32'(pop), 32'h4);
        @(negedge clk);
        check("f6_pop2", 32'(pop), 32'h4);
        @(negedge clk);
        check("f6_pop3_none", 32'(pop), 32'h0);
        drain(20);
        check("idle_after_f6", 32'(idle), 32'd1);

        // Reset in the middle of a stream from F5
        for (int j = 0; j < 8; j++) begin
            load(1, 12'h150 + 12'(j));
            expect_word(1, 12'h150 + 12'(j));
        end
        repeat (5) @(negedge clk);
        #2 reset_L = 1'b0;
        #1;
        check("mid_rst_pop", 32'(pop), 32'd0);
        check("mid_rst_data_valid", 32'(data_valid), 32'd0);
        check("mid_rst_data_rx", 32'(data_rx), 32'd0);
        check("mid_rst_dest_rx", 32'(dest_rx), 32'd0);
        check("mid_rst_cnt_valid", 32'(cnt_valid), 32'd0);
        check("mid_rst_cnt_data", 32'(cnt_data), 32'd0);
        check("mid_rst_idle", 32'(idle), 32'd0);
        for (int k = 0; k < 4; k++) fq[k].delete();
        exp_pop.delete();
        exp_data.delete();
        exp_lat.delete();
        exp_cnt.delete();
        repeat (2) @(negedge clk);
        check("held_rst_data_valid", 32'(data_valid), 32'd0);
        #2 reset_L = 1'b1;
        @(negedge clk);
        check("release_idle", 32'(idle), 32'd0);
        check("release_pop", 32'(pop), 32'd0);
        @(negedge clk);
        check("release_to_idle", 32'(idle), 32'd1);

        // Class/dest-coded word through F6, then counter reads
        load(2, 12'b101011111111);
        expect_word(2, 12'hAFF);
        drain(20);
        read_cnt(3'b110, 5'd1);
        read_cnt(3'b010, 5'd0);
        read_cnt(3'b101, 5'd0);
        read_cnt(3'b100, 5'd0);
        end_reads();

        // 33 words through F4: counter wraps or saturates
        for (int j = 0; j < 33; j++) begin
            load(0, 12'(j));
            expect_word(0, 12'(j));
        end
        drain(60);
        read_cnt(3'b100, F4Count);
        read_cnt(3'b110, 5'd1);
        read_cnt(3'b111, 5'd0);
        end_reads();
        check("idle_end", 32'(idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
